reg_file_param: RTL

Parametrised general-purpose register file for the datapath, the next generation of the existing 32×64 register file. It adds configurable width and depth and a same-cycle write-to-read bypass. It also adds a multi-cycle reinitialise sequence with a busy/done handshake and an optional hard-wired zero register. It sits between decode (read addresses) and writeback (write port).

---
 rtl/reg_file_param.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// ============================================================================
// reg_file_param
// ----------------------------------------------------------------------------
// Parametrised general-purpose register file for the datapath. It sits between
// decode (which supplies the read addresses) and writeback (which drives the
// write port).
//
// Features:
//   - Two combinational read ports with a same-cycle write-to-read bypass.
//   - One synchronous write port, active only while the block is idle.
//   - A multi-cycle reinitialise sequence that rewrites every register with
//     its own index, one register per clock, with a busy / init_done
//     handshake.
//   - Optional hard-wired zero register 0, selected by defining the macro
//     REGFILE_X0_ZERO_EN at compile time.
//
// Parameters:
//   XLEN   register width in bits
//   DEPTH  number of registers (power of two, at least 2)
//   AW     address width, must equal log2(DEPTH)
//
// Ports:
//   clk        in   clock, all state changes on its rising edge
//   reset_n    in   asynchronous active-low reset
//   RS1, RS2   in   read addresses
//   RD         in   write address
//   WriteData  in   write data
//   RegWrite   in   write enable
//   ReadData1  out  read data, port 1 (combinational)
//   ReadData2  out  read data, port 2 (combinational)
//   init_req   in   single-cycle request to reinitialise every register
//   busy       out  high while the reinitialise sequence runs
//   init_done  out  one-cycle pulse when the sequence completes
// ============================================================================
module reg_file_param #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [AW-1:0]   RS1,
   input  logic [AW-1:0]   RS2,
   input  logic [AW-1:0]   RD,
   input  logic [XLEN-1:0] WriteData,
   input  logic            RegWrite,
   output logic [XLEN-1:0] ReadData1,
   output logic [XLEN-1:0] ReadData2,
   input  logic            init_req,
   output logic            busy,
   output logic            init_done
);

   // Register 0 is either an ordinary register or a hard-wired zero.
`ifdef REGFILE_X0_ZERO_EN
   localparam bit X0_ZERO = 1'b1;
`else
   localparam bit X0_ZERO = 1'b0;
`endif

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      INIT = 1'b1
   } state_t;

   state_t          state;
   logic [AW-1:0]   idx;
   logic [XLEN-1:0] regs [DEPTH];

   logic            write_live;
   logic            rd_is_zero;

   // A write is only honoured while idle; with the zero register enabled a
   // write aimed at address 0 is treated as if it never happened, which also
   // keeps it out of the bypass path.
   assign rd_is_zero = (RD == '0);
   assign write_live = RegWrite && (state == IDLE) && !(X0_ZERO && rd_is_zero);

   // Control FSM. The request edge arms the index at 0 and raises busy; each
   // INIT cycle advances the index, and the edge that rewrites the last
   // register returns to IDLE, drops busy and fires the one-cycle done pulse.
   // init_req is only looked at in IDLE, so a request while busy is ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         idx       <= '0;
         busy      <= 1'b0;
         init_done <= 1'b0;
      end else begin
         init_done <= 1'b0;
         case (state)
            IDLE: begin
               if (init_req) begin
                  state <= INIT;
                  idx   <= '0;
                  busy  <= 1'b1;
               end
            end
            INIT: begin
               if (idx == LAST_IDX) begin
                  state     <= IDLE;
                  idx       <= '0;
                  busy      <= 1'b0;
                  init_done <= 1'b1;
               end else begin
                  idx <= idx + AW'(1);
               end
            end
            default: begin
               state <= IDLE;
               idx   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Storage array, one flop group per register so each can carry its own
   // reset value (its index). Register 0 resets to 0 in both configurations,
   // and with the zero register enabled it never accepts a write because
   // write_live excludes address 0 and the INIT value for it is 0 anyway.
   for (genvar g = 0; g < DEPTH; g++) begin : g_reg
      localparam logic [AW-1:0]   MY_ADDR  = AW'(g);
      localparam logic [XLEN-1:0] MY_INDEX = XLEN'(g);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            regs[g] <= MY_INDEX;
         end else if (state == INIT) begin
            if (idx == MY_ADDR) begin
               regs[g] <= MY_INDEX;
            end
         end else if (write_live && (RD == MY_ADDR)) begin
            regs[g] <= WriteData;
         end
      end
   end

   // Read port 1: the array value, replaced by the in-flight write data when
   // the same register is being written this cycle.
   always_comb begin
      ReadData1 = regs[RS1];
      if (write_live && (RD == RS1)) begin
         ReadData1 = WriteData;
      end
      if (X0_ZERO && (RS1 == '0)) begin
         ReadData1 = '0;
      end
   end

   // Read port 2: identical structure to port 1; both may bypass at once.
   always_comb begin
      ReadData2 = regs[RS2];
      if (write_live && (RD == RS2)) begin
         ReadData2 = WriteData;
      end
      if (X0_ZERO && (RS2 == '0)) begin
         ReadData2 = '0;
      end
   end

endmodule
